// File: rtl/dbus_req_buffer_pkg.sv
// Shared data-bus request/response types used by the core memory stage and the bus.
package dbus_req_buffer_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_req_buffer.sv
// Registered request buffer: latches one core request, drives it on the data bus,
// tracks the addr/data handshakes and returns a one-cycle completion to the core.
module dbus_req_buffer
  import dbus_req_buffer_pkg::*;
#(
  parameter int unsigned MAX_WAIT     = 0,
  parameter logic [31:0] TIMEOUT_DATA = 32'hdeadbeef
) (
  input  logic       clk,
  input  logic       resetn,
  input  dbus_req_t  m_req,
  output dbus_resp_t m_resp,
  output dbus_req_t  s_req,
  input  dbus_resp_t s_resp,
  output logic       timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam bit WD_EN = (MAX_WAIT > 0);
  localparam int WCW   = WD_EN ? $clog2(MAX_WAIT + 1) : 1;
  localparam int WAIT_LAST_I = WD_EN ? int'(MAX_WAIT) - 1 : 0;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LAST_I);

  state_e          state_q, state_d;
  dbus_req_t       buf_q, buf_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic            timeout_q, timeout_d;
  logic            wd_hit;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      rdata_q    <= '0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      rdata_q    <= rdata_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign wd_hit = WD_EN && (wait_cnt_q == WAIT_LAST);

  // A real completion always wins over the watchdog in the same cycle.
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    rdata_d    = rdata_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = 1'b0;
    if (WD_EN && (state_q == S_ADDR || state_q == S_DATA) && !wd_hit) begin
      wait_cnt_d = wait_cnt_q + WCW'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (m_req.valid) begin
          buf_d      = m_req;
          wait_cnt_d = '0;
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (s_resp.addr_ok && s_resp.data_ok) begin
          rdata_d = s_resp.data;
          state_d = S_DONE;
        end else if (wd_hit) begin
          rdata_d   = TIMEOUT_DATA;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else if (s_resp.addr_ok) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (s_resp.data_ok) begin
          rdata_d = s_resp.data;
          state_d = S_DONE;
        end else if (wd_hit) begin
          rdata_d   = TIMEOUT_DATA;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_req       = buf_q;
    s_req.valid = (state_q == S_ADDR);
    m_resp      = '0;
    if (state_q == S_DONE) begin
      m_resp.addr_ok = 1'b1;
      m_resp.data_ok = 1'b1;
      m_resp.data    = rdata_q;
    end
  end

  assign timeout = timeout_q;

endmodule

// File: tb/tb_dbus_req_buffer.sv
// Directed bench for dbus_req_buffer: default instance plus a MAX_WAIT=4 watchdog instance.
module tb_dbus_req_buffer;
  import dbus_req_buffer_pkg::*;

  logic       clk;
  logic       resetn;
  dbus_req_t  m_req, m_req_w;
  dbus_resp_t m_resp, m_resp_w;
  dbus_req_t  s_req, s_req_w;
  dbus_resp_t s_resp, s_resp_w;
  logic       timeout, timeout_w;

  int n_tests = 0;
  int n_fail  = 0;

  dbus_req_buffer dut (
    .clk(clk), .resetn(resetn), .m_req(m_req), .m_resp(m_resp),
    .s_req(s_req), .s_resp(s_resp), .timeout(timeout)
  );

  dbus_req_buffer #(.MAX_WAIT(4), .TIMEOUT_DATA(32'hdeadbeef)) dut_wd (
    .clk(clk), .resetn(resetn), .m_req(m_req_w), .m_resp(m_resp_w),
    .s_req(s_req_w), .s_resp(s_resp_w), .timeout(timeout_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    m_req = '0; m_req_w = '0; s_resp = '0; s_resp_w = '0;
    tick; tick;
    n_tests++;
    if (s_req !== '0) begin n_fail++; $display("FAIL reset_s_req: got %h expected 0", s_req); end
    n_tests++;
    if (m_resp !== '0) begin n_fail++; $display("FAIL reset_m_resp: got %h expected 0", m_resp); end
    n_tests++;
    if (timeout !== 1'b0 || timeout_w !== 1'b0) begin
      n_fail++; $display("FAIL reset_timeout: got %b/%b expected 0/0", timeout, timeout_w);
    end
    resetn = 1'b1;
    tick;
    n_tests++;
    if (s_req_w !== '0 || m_resp_w !== '0) begin
      n_fail++; $display("FAIL reset_wd_outputs: got %h/%h expected 0/0", s_req_w, m_resp_w);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_single_cycle;
    m_req = '{valid: 1'b1, addr: 32'h8000_0010, size: MSIZE4, strobe: 4'b0000, data: 32'h0};
    tick;
    m_req.valid = 1'b0;
    n_tests++;
    if (s_req.valid !== 1'b1 || s_req.addr !== 32'h8000_0010 || s_req.size !== MSIZE4) begin
      n_fail++; $display("FAIL single_issue: got valid=%b addr=%h expected 1 80000010", s_req.valid, s_req.addr);
    end
    n_tests++;
    if (m_resp.data_ok !== 1'b0) begin n_fail++; $display("FAIL single_early_ok: got %b expected 0", m_resp.data_ok); end
    s_resp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h1234_5678};
    tick;
    s_resp = '0;
    n_tests++;
    if (m_resp.data_ok !== 1'b1 || m_resp.addr_ok !== 1'b1 || m_resp.data !== 32'h1234_5678) begin
      n_fail++; $display("FAIL single_done: got ok=%b%b data=%h expected 11 12345678", m_resp.addr_ok, m_resp.data_ok, m_resp.data);
    end
    n_tests++;
    if (s_req.valid !== 1'b0 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL single_valid_width: got valid=%b timeout=%b expected 0 0", s_req.valid, timeout);
    end
    tick;
    n_tests++;
    if (m_resp.data_ok !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %b expected 0", m_resp.data_ok); end
    $display("[TB] single-cycle read 80000010 -> 12345678");
  endtask

  task automatic test_split;
    m_req = '{valid: 1'b1, addr: 32'h8000_0020, size: MSIZE2, strobe: 4'b0011, data: 32'h0000_abcd};
    tick;
    m_req.valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_tests++;
      if (s_req.valid !== 1'b1 || s_req.addr !== 32'h8000_0020 || s_req.strobe !== 4'b0011 ||
          s_req.data !== 32'h0000_abcd) begin
        n_fail++; $display("FAIL split_addr_hold c%0d: got v=%b a=%h s=%b d=%h expected 1 80000020 0011 0000abcd",
                           c, s_req.valid, s_req.addr, s_req.strobe, s_req.data);
      end
      if (c == 3) s_resp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'h0};
      tick;
    end
    s_resp = '0;
    for (int c = 4; c <= 6; c++) begin
      n_tests++;
      if (s_req.valid !== 1'b0 || s_req.addr !== 32'h8000_0020 || m_resp.data_ok !== 1'b0) begin
        n_fail++; $display("FAIL split_data_phase c%0d: got v=%b a=%h ok=%b expected 0 80000020 0",
                           c, s_req.valid, s_req.addr, m_resp.data_ok);
      end
      if (c == 6) s_resp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'hfeed_0001};
      tick;
    end
    s_resp = '0;
    n_tests++;
    if (m_resp.data_ok !== 1'b1 || m_resp.data !== 32'hfeed_0001 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL split_done: got ok=%b data=%h to=%b expected 1 feed0001 0", m_resp.data_ok, m_resp.data, timeout);
    end
    tick;
    $display("[TB] split write 80000020 strobe 0011 done");
  endtask

  task automatic test_churn;
    m_req = '{valid: 1'b1, addr: 32'h8000_0040, size: MSIZE4, strobe: 4'b0000, data: 32'h0};
    tick;
    m_req.addr = 32'h0;
    tick;
    n_tests++;
    if (s_req.valid !== 1'b1 || s_req.addr !== 32'h8000_0040) begin
      n_fail++; $display("FAIL churn_addr: got v=%b a=%h expected 1 80000040", s_req.valid, s_req.addr);
    end
    m_req.valid = 1'b0;
    s_resp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0000_0055};
    tick;
    s_resp = '0;
    n_tests++;
    if (m_resp.data_ok !== 1'b1 || m_resp.data !== 32'h0000_0055) begin
      n_fail++; $display("FAIL churn_done: got ok=%b data=%h expected 1 00000055", m_resp.data_ok, m_resp.data);
    end
    tick;
    $display("[TB] churned request kept addr 80000040");
  endtask

  task automatic test_reset_mid;
    m_req = '{valid: 1'b1, addr: 32'h8000_0080, size: MSIZE4, strobe: 4'b0000, data: 32'h0};
    tick;
    m_req.valid = 1'b0;
    s_resp = '{addr_ok: 1'b1, data_ok: 1'b0, data: 32'h0};
    tick;
    s_resp = '0;
    n_tests++;
    if (s_req.valid !== 1'b0 || s_req.addr !== 32'h8000_0080) begin
      n_fail++; $display("FAIL midrst_in_data: got v=%b a=%h expected 0 80000080", s_req.valid, s_req.addr);
    end
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    s_resp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'h0000_0099};
    n_tests++;
    if (s_req !== '0 || m_resp !== '0 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL midrst_after_reset: got s=%h m=%h to=%b expected 0 0 0", s_req, m_resp, timeout);
    end
    tick;
    s_resp = '0;
    n_tests++;
    if (s_req !== '0 || m_resp !== '0) begin
      n_fail++; $display("FAIL midrst_late_data_ok: got s=%h m=%h expected 0 0", s_req, m_resp);
    end
    tick;
    n_tests++;
    if (m_resp.data_ok !== 1'b0) begin n_fail++; $display("FAIL midrst_no_pulse: got %b expected 0", m_resp.data_ok); end
    $display("[TB] reset in DATA aborted transfer");
  endtask

  task automatic test_watchdog;
    m_req_w = '{valid: 1'b1, addr: 32'h8000_0100, size: MSIZE4, strobe: 4'b0000, data: 32'h0};
    tick;
    m_req_w.valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_tests++;
      if (s_req_w.valid !== 1'b1 || m_resp_w.data_ok !== 1'b0 || timeout_w !== 1'b0) begin
        n_fail++; $display("FAIL wd_wait c%0d: got v=%b ok=%b to=%b expected 1 0 0", c, s_req_w.valid, m_resp_w.data_ok, timeout_w);
      end
      tick;
    end
    n_tests++;
    if (m_resp_w.data_ok !== 1'b1 || m_resp_w.data !== 32'hdeadbeef || timeout_w !== 1'b1) begin
      n_fail++; $display("FAIL wd_forced: got ok=%b data=%h to=%b expected 1 deadbeef 1", m_resp_w.data_ok, m_resp_w.data, timeout_w);
    end
    tick;
    n_tests++;
    if (timeout_w !== 1'b0 || m_resp_w.data_ok !== 1'b0) begin
      n_fail++; $display("FAIL wd_pulse_width: got to=%b ok=%b expected 0 0", timeout_w, m_resp_w.data_ok);
    end
    // addr_ok in cycle 2, real data_ok in cycle 4 coincides with the watchdog limit
    m_req_w.valid = 1'b1;
    tick;
    m_req_w.valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      s_resp_w = '0;
      if (c == 2) s_resp_w.addr_ok = 1'b1;
      if (c == 4) s_resp_w = '{addr_ok: 1'b0, data_ok: 1'b1, data: 32'h600d_cafe};
      tick;
    end
    s_resp_w = '0;
    n_tests++;
    if (m_resp_w.data_ok !== 1'b1 || m_resp_w.data !== 32'h600d_cafe || timeout_w !== 1'b0) begin
      n_fail++; $display("FAIL wd_real_wins: got ok=%b data=%h to=%b expected 1 600dcafe 0", m_resp_w.data_ok, m_resp_w.data, timeout_w);
    end
    tick;
    $display("[TB] watchdog forced and coincident completions");
  endtask

  task automatic test_back_to_back;
    int t1, t2, n_done;
    logic [31:0] a2;
    t1 = -1; t2 = -1; n_done = 0; a2 = '0;
    s_resp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 32'h0000_1111};
    m_req = '{valid: 1'b1, addr: 32'h8000_0200, size: MSIZE4, strobe: 4'b0000, data: 32'h0};
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (s_req.valid === 1'b1) begin
        if (t1 < 0) t1 = c;
        else if (t2 < 0) begin t2 = c; a2 = s_req.addr; end
      end
      if (m_resp.data_ok === 1'b1) begin
        n_done++;
        if (n_done == 1) m_req.addr = 32'h8000_0204;
        else m_req.valid = 1'b0;
      end
    end
    s_resp = '0;
    m_req = '0;
    n_tests++;
    if (t2 - t1 !== 3) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 3", t2 - t1); end
    n_tests++;
    if (a2 !== 32'h8000_0204) begin n_fail++; $display("FAIL b2b_second_addr: got %h expected 80000204", a2); end
    n_tests++;
    if (n_done !== 2) begin n_fail++; $display("FAIL b2b_completions: got %0d expected 2", n_done); end
    $display("[TB] back-to-back reads 80000200/80000204");
  endtask

  initial begin
    test_reset;
    test_single_cycle;
    test_split;
    test_churn;
    test_reset_mid;
    test_watchdog;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
